// File: rtl/word_serializer.sv
// word_serializer: loads a NUM_TERMS-word parallel vector and streams it out
// one WORD_WIDTH word per beat over a valid/ready handshake.
// Optional macro WORD_SERIALIZER_REVERSE_EN: emit word NUM_TERMS-1 first,
// with o_index counting down and o_last on index 0.
module word_serializer #(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_TERMS  = 72
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic                                                  i_valid,
    output logic                                                  o_ready,
    input  logic [NUM_TERMS*WORD_WIDTH-1:0]                       i_terms,
    output logic                                                  o_valid,
    input  logic                                                  i_ready,
    output logic [WORD_WIDTH-1:0]                                 o_word,
    output logic                                                  o_last,
    output logic [((NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1)-1:0]  o_index
);

    localparam int IDX_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int VEC_W = NUM_TERMS * WORD_WIDTH;

`ifdef WORD_SERIALIZER_REVERSE_EN
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NUM_TERMS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
    localparam logic [IDX_W-1:0] FIRST_IDX = '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TERMS - 1);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_WIDTH-1:0] cur_word;
    logic               in_send;
    logic               at_last;
    logic               xfer;
    logic               accept;

    // The vector is held in a shift register so the current word always sits
    // at a fixed end; this avoids a wide NUM_TERMS-way output multiplexer.
`ifdef WORD_SERIALIZER_REVERSE_EN
    assign cur_word = buf_q[VEC_W-1 -: WORD_WIDTH];
`else
    assign cur_word = buf_q[WORD_WIDTH-1:0];
`endif

    // Handshake outputs and next-state: accept has priority over beat
    // advance, so a vector accepted on the last beat reloads without a bubble.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;

        in_send = (state_q == SEND);
        at_last = in_send && (idx_q == LAST_IDX);
        xfer    = in_send && i_ready;
        o_ready = !in_send || (xfer && at_last);
        accept  = i_valid && o_ready;

        o_valid = in_send;
        o_last  = at_last;
        o_index = in_send ? idx_q : '0;
        o_word  = in_send ? cur_word : '0;

        if (accept) begin
            state_d = SEND;
            buf_d   = i_terms;
            idx_d   = FIRST_IDX;
        end else if (xfer) begin
            if (at_last) begin
                state_d = IDLE;
                buf_d   = '0;
                idx_d   = '0;
            end else begin
`ifdef WORD_SERIALIZER_REVERSE_EN
                buf_d = buf_q << WORD_WIDTH;
                idx_d = idx_q - IDX_W'(1);
`else
                buf_d = buf_q >> WORD_WIDTH;
                idx_d = idx_q + IDX_W'(1);
`endif
            end
        end
    end

    // State, vector buffer and index registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

endmodule
